// File: rtl/pwm_peripheral.sv
// 16-channel output driver: each pin off, static on, or PWM from one shared prescaled counter.
// Optional macro PWM_SYNC_UPDATE_EN latches the duty cycle into a shadow register at each period wrap.
module pwm_peripheral #(
    parameter int PRESCALE   = 13,
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);
    localparam logic [PRESCALE_W-1:0] PRESCALE_ONE  = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] PRESCALE_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [7:0]            PWM_LAST      = 8'd254;
    localparam logic [7:0]            DUTY_ZERO     = 8'h00;
    localparam logic [7:0]            DUTY_FULL     = 8'hFF;

    logic [PRESCALE_W-1:0] prescale_cnt_r;
    logic [PRESCALE_W-1:0] prescale_cnt_next_s;
    logic [7:0]            pwm_cnt_r;
    logic [7:0]            pwm_cnt_next_s;
    logic                  tick_s;
    logic                  wrap_s;
    logic                  pwm_high_s;
    logic [7:0]            duty_active_s;
    logic [15:0]           en_out_s;
    logic [15:0]           en_pwm_s;
    logic [15:0]           out_next_s;
    logic [15:0]           out_r;
    logic                  period_start_r;

    assign en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Prescaler and PWM counter next-state; the PWM counter skips 255 so a period is 255 steps
    always_comb begin
        tick_s = (prescale_cnt_r == PRESCALE_LAST);
        wrap_s = tick_s && (pwm_cnt_r == PWM_LAST);
        if (tick_s) begin
            prescale_cnt_next_s = PRESCALE_ZERO;
        end else begin
            prescale_cnt_next_s = prescale_cnt_r + PRESCALE_ONE;
        end
        if (wrap_s) begin
            pwm_cnt_next_s = 8'd0;
        end else if (tick_s) begin
            pwm_cnt_next_s = pwm_cnt_r + 8'd1;
        end else begin
            pwm_cnt_next_s = pwm_cnt_r;
        end
    end

`ifdef PWM_SYNC_UPDATE_EN
    logic [7:0] duty_shadow_r;

    // Shadow duty register: only updated on the wrap so every period is glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow_r <= 8'h00;
        end else if (wrap_s) begin
            duty_shadow_r <= pwm_duty_cycle;
        end else begin
            duty_shadow_r <= duty_shadow_r;
        end
    end

    assign duty_active_s = duty_shadow_r;
`else
    assign duty_active_s = pwm_duty_cycle;
`endif

    // Duty compare (0xFF forced to a true 100%) and per-channel off/on/PWM select
    always_comb begin
        if (duty_active_s == DUTY_ZERO) begin
            pwm_high_s = 1'b0;
        end else if (duty_active_s == DUTY_FULL) begin
            pwm_high_s = 1'b1;
        end else begin
            pwm_high_s = (pwm_cnt_r < duty_active_s);
        end
        out_next_s = en_out_s & (~en_pwm_s | {16{pwm_high_s}});
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_cnt_r <= PRESCALE_ZERO;
            pwm_cnt_r      <= 8'd0;
            out_r          <= 16'h0000;
            period_start_r <= 1'b0;
        end else begin
            prescale_cnt_r <= prescale_cnt_next_s;
            pwm_cnt_r      <= pwm_cnt_next_s;
            out_r          <= out_next_s;
            period_start_r <= wrap_s;
        end
    end

    assign out          = out_r;
    assign period_start = period_start_r;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral: expected outputs come from a time-since-reset arithmetic model.
module tb_pwm_peripheral;

    localparam int P      = 2;
    localparam int PERIOD = 255 * P;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] en_out = 16'h0000;
    logic [15:0] en_pwm = 16'h0000;
    logic [7:0]  duty   = 8'h00;
    logic [15:0] out;
    logic        period_start;

    typedef struct packed {
        logic [15:0] out;
        logic        ps;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks   = 0;
    int    n_fail     = 0;
    int    n_edges    = 0;
    logic [7:0] duty_act_m = 8'h00;

    pwm_peripheral #(.PRESCALE(P), .PRESCALE_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    // Channel rule applied bit by bit from the duty and the counter position in the period
    function automatic logic [15:0] model_out(input logic [15:0] eo, input logic [15:0] ep,
                                              input logic [7:0] d, input int cnt);
        logic        high;
        logic [15:0] r;
        if (d == 8'h00)      high = 1'b0;
        else if (d == 8'hFF) high = 1'b1;
        else                 high = (cnt < int'(d));
        for (int i = 0; i < 16; i++) begin
            if (!eo[i])      r[i] = 1'b0;
            else if (!ep[i]) r[i] = 1'b1;
            else             r[i] = high;
        end
        return r;
    endfunction

    // Expected result of the next clock edge, k edges after reset release
    task automatic push_cycle(input string tag);
        int         k;
        int         cnt;
        logic [7:0] d_eff;
        exp_t       e;
        k   = n_edges + 1;
        cnt = ((k - 1) / P) % 255;
`ifdef PWM_SYNC_UPDATE_EN
        d_eff = duty_act_m;
`else
        d_eff = duty;
`endif
        e.out = model_out(en_out, en_pwm, d_eff, cnt);
        e.ps  = ((k % PERIOD) == 0);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (e.ps) duty_act_m = duty;
        n_edges = k;
    endtask

    task automatic step(input int cycles, input string tag);
        repeat (cycles) begin
            push_cycle(tag);
            @(negedge clk);
        end
    endtask

    task automatic push_zero(input string tag);
        exp_t e;
        e.out = 16'h0000;
        e.ps  = 1'b0;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic do_reset(input int cycles);
        push_zero("reset_async");
        rst_n = 1'b0;
        repeat (cycles) begin
            push_zero("reset_hold");
            @(negedge clk);
        end
        rst_n      = 1'b1;
        n_edges    = 0;
        duty_act_m = 8'h00;
    endtask

    // Monitor: one scoreboard entry per clock edge and per asynchronous reset assertion
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL queue_empty at %0t: got output with no expectation", $time);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_checks++;
                if (out !== e.out) begin
                    n_fail++;
                    $display("FAIL %s out at %0t: got %h expected %h", t, $time, out, e.out);
                end
                n_checks++;
                if (period_start !== e.ps) begin
                    n_fail++;
                    $display("FAIL %s period_start at %0t: got %b expected %b", t, $time, period_start, e.ps);
                end
            end
        end
    end

    initial begin
        int r;
        #1;
        do_reset(3);

        en_out = 16'h00FF; en_pwm = 16'h0000; duty = 8'h55;
        step(3 * PERIOD, "static_on");

        en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'h80;
        step(2 * PERIOD, "pwm_50");

        duty = 8'h00;
        step(2 * PERIOD, "duty_00");
        duty = 8'hFF;
        step(2 * PERIOD, "duty_ff");

        en_out = 16'hF0F0; en_pwm = 16'hA0A0; duty = 8'h40;
        step(PERIOD, "mixed");

        en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'h40;
        step(PERIOD, "pre_change");
        while ((n_edges % PERIOD) != 0) step(1, "align");
        while (((n_edges / P) % 255) != 100) step(1, "to_cnt100");
        duty = 8'hC0;
        step(2 * PERIOD, "duty_change");

        repeat (20) begin
            en_out = 16'($urandom());
            en_pwm = 16'($urandom());
            r = int'($urandom_range(0, 3));
            if (r == 0)      duty = 8'h00;
            else if (r == 1) duty = 8'hFF;
            else             duty = 8'($urandom());
            step(int'($urandom_range(1, 600)), "random");
        end

        en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'h80;
        step(100, "pre_reset");
        do_reset(5);
        step(PERIOD + 20, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five 8-bit configuration registers produced by the SPI register-write stage and drives 16 registered output pins.
- Each pin is either off, statically on, or toggling at a shared PWM duty cycle.
- Sits directly downstream of the SPI peripheral; its outputs go to the chip's uo_out/uio_out pins.

Parameters:
- PRESCALE, 13, clk cycles per PWM counter step; must be >= 1. Default gives about 3 kHz PWM at 10 MHz clk.
- PRESCALE_W, 8, width of the prescaler counter; must hold PRESCALE-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en_reg_out_7_0  input  8  output enable, channels 7..0
- en_reg_out_15_8  input  8  output enable, channels 15..8
- en_reg_pwm_7_0  input  8  PWM mode select, channels 7..0
- en_reg_pwm_15_8  input  8  PWM mode select, channels 15..8
- pwm_duty_cycle  input  8  shared duty value, 0x00..0xFF
- out  output  16  channel outputs (registered)
- period_start  output  1  one-clk pulse at each PWM period start (registered)

Behaviour:
- Inputs are treated as quasi-static and already in the clk domain. No resynchronisation.
- Reset (rst_n low, async) clears: prescale counter = 0, pwm_cnt = 0, out = 16'h0000, period_start = 0, duty_active = 0. All outputs hold these values while rst_n is low.
- Release is synchronous: counting starts on the first clk edge with rst_n high.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps to 0.
  - tick = (prescale counter == PRESCALE-1).
  - PRESCALE=1 gives tick every clk.
- PWM counter pwm_cnt (8 bit):
  - Advances only on tick; counts 0..254, then wraps to 0. Value 255 is never reached.
  - Period = 255*PRESCALE clk.
- Wrap event: tick with pwm_cnt == 254.
  - period_start is registered high for exactly one clk, in the cycle in which pwm_cnt becomes 0.
- pwm_high, computed from duty_active:
  - 0x00 gives always 0.
  - 0xFF gives always 1 (true 100%).
  - Otherwise pwm_high = (pwm_cnt < duty_active).
  - High time = duty*PRESCALE clk per period.
- Channel i, 16 bits formed by concatenating {15_8, 7_0}:
  - en_out[i]=0 gives 0.
  - en_out[i]=1 and en_pwm[i]=0 gives 1.
  - en_out[i]=1 and en_pwm[i]=1 gives pwm_high.
- out is registered. Changes to enable or mode inputs appear on out exactly 1 clk later, not aligned to the period.
- All PWM-mode channels toggle in phase, sharing one counter.
- A duty change never resets pwm_cnt or the prescaler.
- duty_active = pwm_duty_cycle, used directly (see Optional Feature for the alternative).
- Async reset mid-period aborts immediately. The period restarts from pwm_cnt=0 after release.

Optional Feature:
- Macro: PWM_SYNC_UPDATE_EN
- Defined:
  - duty_active is a shadow register, reset to 0x00.
  - It loads pwm_duty_cycle only on the wrap event, the same clk edge pwm_cnt returns to 0.
  - Result: glitch-free periods, and duty changes take effect at the next period start.
  - After reset, PWM channels read low until the first wrap.
- Undefined: no shadow register. The compare uses pwm_duty_cycle combinationally, and a change takes effect at the next out register update.

Test Plan:
- Reset: rst_n=0 mid-run with all enables 0xFF, duty 0x80 -> out=0x0000 and period_start=0 asynchronously. After release, first period_start comes 255*PRESCALE clk later.
- Static on: en_out=0x00FF, en_pwm=0x0000 -> out=0x00FF one clk after the inputs settle, constant over 3 periods.
- 50% PWM: PRESCALE=2, en_out=en_pwm=0xFFFF, duty=0x80 -> every bit of out high for 256 clk and low for 254 clk per 510-clk period, all bits identical.
- Extremes: duty=0x00 -> PWM bits constantly 0. duty=0xFF -> constantly 1. Both checked over 2 full periods.
- Mixed: en_out=0xF0F0, en_pwm=0xA0A0, duty=0x40 -> bits 15,13,7,5 PWM; bits 14,12,6,4 static 1; others 0.
- Duty change mid-period: PRESCALE=2, duty 0x40 changed to 0xC0 at pwm_cnt=100.
  - With PWM_SYNC_UPDATE_EN: current period keeps its 128-clk high time; the next period is high for 384 clk.
  - Without it: output goes high again in the same period, 1 clk after the change.
